// File: rtl/fifo_pixel_reader_if.sv
// FIFO read port and frame-buffer write port seen by the pixel reader.
// master: the reader (consumes FIFO bytes, drives frame-buffer writes).
// slave:  the FIFO / frame-buffer side.
interface fifo_pixel_reader_if #(
    parameter int dat_width    = 8,
    parameter int fb_adr_width = 15
);
    logic [dat_width-1:0]    fifo_data;
    logic                    fifo_empty;
    logic                    rd;
    logic [7:0]              px_data;
    logic [fb_adr_width-1:0] px_addr;
    logic                    px_we;

    modport master (
        input  fifo_data, fifo_empty,
        output rd, px_data, px_addr, px_we
    );

    modport slave (
        output fifo_data, fifo_empty,
        input  rd, px_data, px_addr, px_we
    );
endinterface

// File: rtl/fifo_pixel_reader.sv
// Camera FIFO read side: pairs bytes into RGB565 pixels, converts them to
// RGB332 and writes them to the frame buffer at a linear, per-frame address.
module fifo_pixel_reader #(
    parameter int dat_width    = 8,
    parameter int h_res        = 160,
    parameter int v_res        = 120,
    parameter int fb_adr_width = 15
) (
    input  logic                Pclk,
    input  logic                rst,
    input  logic                start,
    fifo_pixel_reader_if.master bus,
    output logic                busy,
    output logic                frame_done
);
    localparam int COL_W = (h_res > 1) ? $clog2(h_res) : 1;
    localparam int ROW_W = (v_res > 1) ? $clog2(v_res) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BYTE_HI = 2'd1,
        BYTE_LO = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [dat_width-1:0]    r_hi;
    logic [dat_width-1:0]    r_lo;
    logic [COL_W-1:0]        r_col;
    logic [ROW_W-1:0]        r_row;
    logic [fb_adr_width-1:0] r_px_addr;
    logic                    r_frame_done;
    logic                    w_rd;
    logic                    w_last;
    logic                    w_col_wrap;

    // RGB565 {hi,lo} -> RGB332: top 3 bits of R and G, top 2 bits of B.
    function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi,
                                                 input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

    // A byte is taken only in the two byte states and only when the FIFO has
    // one; reset gates the strobe so an aborted frame never eats a byte.
    assign w_rd       = !rst && !bus.fifo_empty &&
                        ((r_state == BYTE_HI) || (r_state == BYTE_LO));
    assign w_col_wrap = (r_col == COL_W'(h_res - 1));
    assign w_last     = w_col_wrap && (r_row == ROW_W'(v_res - 1));

    assign bus.rd      = w_rd;
    assign bus.px_we   = (r_state == WRITE);
    assign bus.px_data = rgb565_to_332(r_hi, r_lo);
    assign bus.px_addr = r_px_addr;
    assign busy        = (r_state != IDLE);
    assign frame_done  = r_frame_done;

    // Frame sequencer: byte pairing, pixel write, col/row/address stepping.
    always_ff @(posedge Pclk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hi         <= '0;
            r_lo         <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_px_addr    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A start coinciding with the end-of-frame pulse is dropped.
                    if (start && !r_frame_done) begin
                        r_col     <= '0;
                        r_row     <= '0;
                        r_px_addr <= '0;
                        r_state   <= BYTE_HI;
                    end
                end
                BYTE_HI: begin
                    if (w_rd) begin
                        r_hi    <= bus.fifo_data;
                        r_state <= BYTE_LO;
                    end
                end
                BYTE_LO: begin
                    if (w_rd) begin
                        r_lo    <= bus.fifo_data;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_last) begin
                        r_col        <= '0;
                        r_row        <= '0;
                        r_px_addr    <= '0;
                        r_frame_done <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_px_addr <= r_px_addr + fb_adr_width'(1);
                        if (w_col_wrap) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                        r_state <= BYTE_HI;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Bench for fifo_pixel_reader (4x3 frame): FIFO model, scoreboard of
// expected pixel writes, and directed sequences around reset/start/stalls.
module tb_fifo_pixel_reader;
    localparam int H    = 4;
    localparam int V    = 3;
    localparam int NPIX = H * V;
    localparam int AW   = 4;

    logic Pclk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic frame_done;

    fifo_pixel_reader_if #(.dat_width(8), .fb_adr_width(AW)) bus ();

    fifo_pixel_reader #(
        .dat_width(8), .h_res(H), .v_res(V), .fb_adr_width(AW)
    ) dut (
        .Pclk(Pclk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 Pclk = ~Pclk;

    typedef struct packed {
        logic [7:0]    data;
        logic [AW-1:0] addr;
    } pix_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    longint     cyc = 0;
    logic [7:0] fifo_q[$];
    pix_t       exp_q[$];
    bit         rand_stall = 0;
    bit         stall_after_first = 0;
    int         stall_cnt = 0;
    bit         rd_prev = 0;
    int         rd_cnt = 0, we_cnt = 0, fd_cnt = 0, rd_while_empty = 0;
    longint     first_rd_cyc = -1, first_we_cyc = -1, first_busy_cyc = -1, fd_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RGB565 word split into its fields, then each field truncated to RGB332.
    function automatic logic [7:0] model_px(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] w;
        logic [4:0]  r;
        logic [5:0]  g;
        logic [4:0]  b;
        w = {hi, lo};
        r = w[15:11];
        g = w[10:5];
        b = w[4:0];
        return {r[4:2], g[5:3], b[4:3]};
    endfunction

    always @(posedge Pclk) cyc <= cyc + 1;

    // FIFO model: pops the byte the DUT read, then presents the next one.
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = 8'h00;
        forever begin
            @(posedge Pclk);
            #1;
            if (rd_prev) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                rd_prev = 0;
                if (stall_after_first) begin
                    stall_after_first = 0;
                    stall_cnt = 5;
                end
            end
            if (stall_cnt > 0) begin
                stall_cnt--;
                bus.fifo_empty = 1'b1;
            end else if (fifo_q.size() == 0) begin
                bus.fifo_empty = 1'b1;
            end else begin
                bus.fifo_empty = rand_stall && ($urandom_range(0, 3) == 0);
            end
            bus.fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        end
    end

    // Monitor: sampled mid-cycle; every px_we is matched against the scoreboard.
    always @(negedge Pclk) begin
        pix_t e;
        rd_prev = bus.rd;
        if (bus.rd) begin
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (bus.fifo_empty) rd_while_empty++;
        end
        if (busy && first_busy_cyc < 0) first_busy_cyc = cyc;
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (bus.px_we) begin
            we_cnt++;
            if (first_we_cyc < 0) first_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL px_unexpected: write data 0x%0h addr %0d, expected no write",
                         bus.px_data, bus.px_addr);
            end else begin
                e = exp_q.pop_front();
                check("px_data", 32'(bus.px_data), 32'(e.data));
                check("px_addr", 32'(bus.px_addr), 32'(e.addr));
            end
        end
    end

    task automatic tick();
        @(posedge Pclk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_marks();
        rd_cnt = 0; we_cnt = 0; fd_cnt = 0;
        first_rd_cyc = -1; first_we_cyc = -1; first_busy_cyc = -1; fd_cyc = -1;
    endtask

    // Queue one frame of bytes and the pixel writes they must produce.
    task automatic load_frame(input bit fixed_head);
        logic [7:0] hi, lo;
        pix_t p;
        for (int k = 0; k < NPIX; k++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            p.data = model_px(hi, lo);
            if (fixed_head && k == 0) begin hi = 8'hF8; lo = 8'h1F; p.data = 8'hE3; end
            if (fixed_head && k == 1) begin hi = 8'h07; lo = 8'hE0; p.data = 8'h1C; end
            p.addr = AW'(k);
            fifo_q.push_back(hi);
            fifo_q.push_back(lo);
            exp_q.push_back(p);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (frame_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no frame_done within %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"},         32'(bus.rd),         32'd0);
        check({tag, "_px_we"},      32'(bus.px_we),      32'd0);
        check({tag, "_px_data"},    32'(bus.px_data),    32'd0);
        check({tag, "_px_addr"},    32'(bus.px_addr),    32'd0);
        check({tag, "_busy"},       32'(busy),           32'd0);
        check({tag, "_frame_done"}, 32'(frame_done),     32'd0);
    endtask

    initial begin
        longint s_cyc;
        bit     hit;
        rst   = 1'b1;
        start = 1'b1;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'h55);
        clear_marks();

        // Reset held with start high and FIFO non-empty.
        repeat (3) tick();
        check_reset_outputs("reset");
        check("reset_rd_count", 32'(rd_cnt), 32'd0);
        check("reset_fifo_untouched", 32'(fifo_q.size()), 32'd2);
        rst   = 1'b0;
        start = 1'b0;
        fifo_q.delete();
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Frame A: known first two pixels, 5-cycle empty stall after high byte.
        clear_marks();
        load_frame(1'b1);
        stall_after_first = 1;
        pulse_start();
        s_cyc = cyc;
        wait_done(300, "frameA_done");
        check("frameA_busy_at_done", 32'(busy), 32'd0);
        check("frameA_addr_at_done", 32'(bus.px_addr), 32'd0);
        tick();
        check("frameA_busy_latency", 32'(first_busy_cyc - s_cyc), 32'd0);
        check("frameA_stall_write_delay", 32'(first_we_cyc - first_rd_cyc), 32'd7);
        check("frameA_we_count", 32'(we_cnt), 32'(NPIX));
        check("frameA_rd_count", 32'(rd_cnt), 32'(2 * NPIX));
        check("frameA_fd_count", 32'(fd_cnt), 32'd1);
        check("frameA_sb_empty", 32'(exp_q.size()), 32'd0);

        // Frame B: FIFO never empty, stray start mid-frame, start on frame_done.
        clear_marks();
        rand_stall = 0;
        load_frame(1'b0);
        pulse_start();
        repeat (10) tick();
        pulse_start();
        wait_done(300, "frameB_done");
        check("frameB_busy_at_done", 32'(busy), 32'd0);
        check("frameB_addr_at_done", 32'(bus.px_addr), 32'd0);
        check("frameB_sb_empty", 32'(exp_q.size()), 32'd0);
        load_frame(1'b0);
        rand_stall = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("frameB_start_on_done_ignored", 32'(busy), 32'd0);
        check("frameB_duration", 32'(fd_cyc - first_busy_cyc), 32'(3 * NPIX));
        check("frameB_fd_count", 32'(fd_cnt), 32'd1);
        check("frameB_we_count", 32'(we_cnt), 32'(NPIX));
        check("frameB_rd_count", 32'(rd_cnt), 32'(2 * NPIX));

        // Frame C: start accepted the cycle after frame_done, reset after 5 pixels.
        clear_marks();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("frameC_start_accepted", 32'(busy), 32'd1);
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (we_cnt >= 5) begin
                hit = 1;
                break;
            end
        end
        check("frameC_reached_5_pixels", 32'(hit), 32'd1);
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("abort");
        check("abort_pending_pixels", 32'(exp_q.size()), 32'(NPIX - 5));
        check("abort_bytes_left", 32'(fifo_q.size()), 32'(2 * NPIX - 10));
        fifo_q.delete();
        exp_q.delete();
        rst = 1'b0;
        tick();

        // Frame D: fresh frame after abort, random stalls.
        clear_marks();
        load_frame(1'b0);
        pulse_start();
        wait_done(500, "frameD_done");
        check("frameD_addr_at_done", 32'(bus.px_addr), 32'd0);
        tick();
        check("frameD_we_count", 32'(we_cnt), 32'(NPIX));
        check("frameD_rd_count", 32'(rd_cnt), 32'(2 * NPIX));
        check("frameD_sb_empty", 32'(exp_q.size()), 32'd0);
        check("rd_while_empty", 32'(rd_while_empty), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
